multicycle_control_unit: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 4-bit opcode decoder for the 16-bit processor.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath control lines for each state.
- Stalls on a memory ready handshake, traps illegal opcodes and counts retired instructions.
- Sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_control_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit processor.
// Steps every instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath control lines for each state. Memory accesses stall on mem_ready,
// illegal opcodes trap, and retired instructions are counted.
module multicycle_control_unit #(
  parameter int OPCODE_W  = 4,
  parameter int ALUOP_W   = 3,
  parameter int CNT_W     = 16,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state
);

  // State codes double as the debug state output.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_BNE = 4'd14;
  localparam logic [3:0] OP_JMP = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] B_REG    = 2'b00;
  localparam logic [1:0] B_ONE    = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_BRANCH = 2'b11;

  // Any set bit above the 4-bit opcode map makes the code illegal.
  function automatic logic upper_clear(input logic [OPCODE_W-1:0] op);
    return (op >> 4) == '0;
  endfunction

  function automatic logic is_rtype(input logic [OPCODE_W-1:0] op);
    logic [3:0] lo;
    lo = op[3:0];
    return upper_clear(op) &&
           (lo == OP_AND || lo == OP_OR || lo == OP_ADD ||
            lo == OP_SUB || lo == OP_SLT);
  endfunction

  function automatic logic is_op(input logic [OPCODE_W-1:0] op,
                                 input logic [3:0]          code);
    return upper_clear(op) && (op[3:0] == code);
  endfunction

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return is_rtype(op) || is_op(op, OP_LW) || is_op(op, OP_SW) ||
           is_op(op, OP_BNE) || is_op(op, OP_JMP);
  endfunction

  // ALU function for R-type instructions; non R-type codes fall back to ADD.
  function automatic logic [2:0] rtype_alu(input logic [OPCODE_W-1:0] op);
    logic [2:0] code;
    case (op[3:0])
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SUB:  code = ALU_SUB;
      OP_SLT:  code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  state_t               state_q, state_d;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [CNT_W-1:0]     count_q;

  // Enable outputs before the reset gate; reset must suppress every write.
  logic       pc_write_raw;
  logic       pc_write_cond_raw;
  logic       ir_write_raw;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       instr_done_raw;
  logic [2:0] alu_code;

  // Next-state selection; DECODE looks at the live opcode, later states at the latched one.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!is_legal(opcode))          state_d = S_TRAP;
        else if (is_op(opcode, OP_JMP)) state_d = S_FETCH;
        else                            state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_rtype(opcode_q))                                  state_d = S_WB;
        else if (is_op(opcode_q, OP_LW) || is_op(opcode_q, OP_SW)) state_d = S_MEM;
        else                                                     state_d = S_FETCH;
      end
      S_MEM: begin
        if (!mem_ready)                 state_d = S_MEM;
        else if (is_op(opcode_q, OP_LW)) state_d = S_WB;
        else                            state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = TRAP_HALT ? S_TRAP : S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Per-state control decode; unlisted outputs stay at zero.
  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    pc_src            = PC_ALU;
    ir_write_raw      = 1'b0;
    i_or_d            = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    reg_write_raw     = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = B_REG;
    alu_code          = ALU_ADD;
    instr_done_raw    = 1'b0;
    illegal_op        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = B_ONE;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = B_BRANCH;
        if (is_op(opcode, OP_JMP)) begin
          pc_write_raw   = 1'b1;
          pc_src         = PC_JUMP;
          instr_done_raw = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_rtype(opcode_q)) begin
          alu_code = rtype_alu(opcode_q);
        end else if (is_op(opcode_q, OP_BNE)) begin
          alu_code          = ALU_SUB;
          pc_write_cond_raw = 1'b1;
          pc_src            = PC_ALUOUT;
          instr_done_raw    = 1'b1;
        end else begin
          alu_src_b = B_IMM;
        end
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (is_op(opcode_q, OP_LW)) begin
          mem_read_raw = 1'b1;
        end else begin
          mem_write_raw  = 1'b1;
          instr_done_raw = mem_ready;
        end
      end
      S_WB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        if (is_op(opcode_q, OP_LW)) mem_to_reg = 1'b1;
        else                        reg_dst    = 1'b1;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Gate all enables with reset so nothing is written while reset is held.
  always_comb begin
    pc_write      = pc_write_raw      & ~reset;
    pc_write_cond = pc_write_cond_raw & ~reset;
    ir_write      = ir_write_raw      & ~reset;
    mem_read      = mem_read_raw      & ~reset;
    mem_write     = mem_write_raw     & ~reset;
    reg_write     = reg_write_raw     & ~reset;
    instr_done    = instr_done_raw    & ~reset;
    alu_op        = ALUOP_W'(alu_code);
  end

  // State, latched opcode and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (instr_done_raw)      count_q  <= count_q + CNT_W'(1);
    end
  end

  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a default instance, a
// non-halting trap instance and a 2-bit counter instance share clock,
// opcode and mem_ready but have separate resets.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset_a, reset_b, reset_c;
  logic [3:0] opcode;
  logic       mem_ready;

  logic       pcw_a, pcwc_a, irw_a, iod_a, mr_a, mw_a, m2r_a, rd_a, rw_a, asa_a, done_a, ill_a;
  logic [1:0] pcs_a, asb_a;
  logic [2:0] aop_a, st_a;
  logic [15:0] cnt_a;

  logic       pcw_b, pcwc_b, irw_b, iod_b, mr_b, mw_b, m2r_b, rd_b, rw_b, asa_b, done_b, ill_b;
  logic [1:0] pcs_b, asb_b;
  logic [2:0] aop_b, st_b;
  logic [15:0] cnt_b;

  logic       pcw_c, pcwc_c, irw_c, iod_c, mr_c, mw_c, m2r_c, rd_c, rw_c, asa_c, done_c, ill_c;
  logic [1:0] pcs_c, asb_c;
  logic [2:0] aop_c, st_c;
  logic [1:0] cnt_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut_a (
    .clk(clk), .reset(reset_a), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_a), .pc_write_cond(pcwc_a), .pc_src(pcs_a), .ir_write(irw_a),
    .i_or_d(iod_a), .mem_read(mr_a), .mem_write(mw_a), .mem_to_reg(m2r_a),
    .reg_dst(rd_a), .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a),
    .alu_op(aop_a), .instr_done(done_a), .illegal_op(ill_a),
    .instr_count(cnt_a), .state(st_a)
  );

  multicycle_control_unit #(.TRAP_HALT(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_b), .pc_write_cond(pcwc_b), .pc_src(pcs_b), .ir_write(irw_b),
    .i_or_d(iod_b), .mem_read(mr_b), .mem_write(mw_b), .mem_to_reg(m2r_b),
    .reg_dst(rd_b), .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b),
    .alu_op(aop_b), .instr_done(done_b), .illegal_op(ill_b),
    .instr_count(cnt_b), .state(st_b)
  );

  multicycle_control_unit #(.CNT_W(2)) dut_c (
    .clk(clk), .reset(reset_c), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_c), .pc_write_cond(pcwc_c), .pc_src(pcs_c), .ir_write(irw_c),
    .i_or_d(iod_c), .mem_read(mr_c), .mem_write(mw_c), .mem_to_reg(m2r_c),
    .reg_dst(rd_c), .reg_write(rw_c), .alu_src_a(asa_c), .alu_src_b(asb_c),
    .alu_op(aop_c), .instr_done(done_c), .illegal_op(ill_c),
    .instr_count(cnt_c), .state(st_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    opcode = 4'd0; mem_ready = 1'b1;
    step();
    #1;
    // Reset: enables forced low even though FETCH with mem_ready=1.
    chk("rst_state", 32'(st_a), 0);
    chk("rst_irw", 32'(irw_a), 0);
    chk("rst_pcw", 32'(pcw_a), 0);
    chk("rst_mr", 32'(mr_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    reset_a = 1'b0;
    #1;
    $display("reset done");

    // ADD: FETCH, DECODE, EXEC, WB.
    chk("add_f_irw", 32'(irw_a), 1);
    chk("add_f_pcw", 32'(pcw_a), 1);
    chk("add_f_asb", 32'(asb_a), 1);
    step(); opcode = 4'd2; #1;
    chk("add_d_state", 32'(st_a), 1);
    chk("add_d_asb", 32'(asb_a), 3);
    step(); #1;
    chk("add_e_state", 32'(st_a), 2);
    chk("add_e_aop", 32'(aop_a), 0);
    chk("add_e_asa", 32'(asa_a), 1);
    step(); #1;
    chk("add_w_state", 32'(st_a), 4);
    chk("add_w_rw", 32'(rw_a), 1);
    chk("add_w_rd", 32'(rd_a), 1);
    chk("add_w_done", 32'(done_a), 1);
    chk("add_w_cnt", 32'(cnt_a), 0);
    step(); #1;
    chk("add_cnt", 32'(cnt_a), 1);
    $display("ADD retired count=%0d", cnt_a);

    // LW with two FETCH stalls and one MEM stall.
    mem_ready = 1'b0; #1;
    chk("lw_f0_irw", 32'(irw_a), 0);
    chk("lw_f0_pcw", 32'(pcw_a), 0);
    step(); #1;
    chk("lw_f1_state", 32'(st_a), 0);
    chk("lw_f1_irw", 32'(irw_a), 0);
    step(); mem_ready = 1'b1; #1;
    chk("lw_f2_irw", 32'(irw_a), 1);
    step(); opcode = 4'd8; #1;
    chk("lw_d_state", 32'(st_a), 1);
    step(); opcode = 4'd2; #1;           // late opcode change must be ignored
    chk("lw_e_state", 32'(st_a), 2);
    chk("lw_e_asb", 32'(asb_a), 2);
    step(); mem_ready = 1'b0; #1;
    chk("lw_m0_state", 32'(st_a), 3);
    chk("lw_m0_mr", 32'(mr_a), 1);
    chk("lw_m0_iod", 32'(iod_a), 1);
    step(); mem_ready = 1'b1; #1;
    chk("lw_m1_state", 32'(st_a), 3);
    step(); #1;
    chk("lw_w_state", 32'(st_a), 4);
    chk("lw_w_m2r", 32'(m2r_a), 1);
    chk("lw_w_rd", 32'(rd_a), 0);
    chk("lw_w_rw", 32'(rw_a), 1);
    step(); #1;
    chk("lw_state", 32'(st_a), 0);
    chk("lw_cnt", 32'(cnt_a), 2);
    $display("LW retired count=%0d", cnt_a);

    // SW then BNE.
    step(); opcode = 4'd10; #1;
    step(); #1;
    chk("sw_e_asb", 32'(asb_a), 2);
    step(); #1;
    chk("sw_m_state", 32'(st_a), 3);
    chk("sw_m_mw", 32'(mw_a), 1);
    chk("sw_m_rw", 32'(rw_a), 0);
    chk("sw_m_done", 32'(done_a), 1);
    step(); #1;
    chk("sw_state", 32'(st_a), 0);
    chk("sw_cnt", 32'(cnt_a), 3);
    step(); opcode = 4'd14; #1;
    step(); #1;
    chk("bne_e_pcwc", 32'(pcwc_a), 1);
    chk("bne_e_pcs", 32'(pcs_a), 1);
    chk("bne_e_aop", 32'(aop_a), 1);
    chk("bne_e_done", 32'(done_a), 1);
    step(); #1;
    chk("bne_state", 32'(st_a), 0);
    chk("bne_cnt", 32'(cnt_a), 4);
    $display("SW+BNE retired count=%0d", cnt_a);

    // JMP: two cycles.
    step(); opcode = 4'd15; #1;
    chk("jmp_d_pcw", 32'(pcw_a), 1);
    chk("jmp_d_pcs", 32'(pcs_a), 2);
    chk("jmp_d_done", 32'(done_a), 1);
    step(); #1;
    chk("jmp_state", 32'(st_a), 0);
    chk("jmp_cnt", 32'(cnt_a), 5);
    $display("JMP retired count=%0d", cnt_a);

    // Illegal opcode 3, halting trap.
    step(); opcode = 4'd3; #1;
    chk("ill_d_done", 32'(done_a), 0);
    step(); #1;
    chk("trap_state", 32'(st_a), 5);
    chk("trap_ill", 32'(ill_a), 1);
    step(); step(); #1;
    chk("trap_hold_state", 32'(st_a), 5);
    chk("trap_hold_ill", 32'(ill_a), 1);
    chk("trap_cnt", 32'(cnt_a), 5);
    reset_a = 1'b1;
    step(); reset_a = 1'b0; #1;
    chk("trap_rst_state", 32'(st_a), 0);
    chk("trap_rst_ill", 32'(ill_a), 0);
    chk("trap_rst_cnt", 32'(cnt_a), 0);
    $display("halting trap cleared by reset");

    // Non-halting trap instance.
    reset_b = 1'b0; #1;
    chk("b_state0", 32'(st_b), 0);
    step(); opcode = 4'd3; #1;
    step(); #1;
    chk("b_trap_state", 32'(st_b), 5);
    chk("b_trap_ill", 32'(ill_b), 1);
    step(); #1;
    chk("b_after_state", 32'(st_b), 0);
    chk("b_after_ill", 32'(ill_b), 0);
    chk("b_cnt", 32'(cnt_b), 0);
    $display("non-halting trap returned to FETCH");

    // 2-bit counter wrap via five JMPs.
    reset_c = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = 2'(i + 1);
      step(); opcode = 4'd15; #1;
      chk("c_jmp_done", 32'(done_c), 1);
      step(); #1;
      chk("c_wrap_cnt", 32'(cnt_c), 32'(exp_cnt));
      $display("CNT_W=2 jmp %0d count=%0d", i, cnt_c);
    end

    // Reset asserted in BNE EXEC: enables suppressed, no increment.
    step(); opcode = 4'd14; #1;
    step(); #1;
    chk("c_bne_state", 32'(st_c), 2);
    chk("c_bne_done", 32'(done_c), 1);
    reset_c = 1'b1; #1;
    chk("c_rst_done", 32'(done_c), 0);
    chk("c_rst_pcwc", 32'(pcwc_c), 0);
    step(); #1;
    chk("c_rst_state", 32'(st_c), 0);
    chk("c_rst_cnt", 32'(cnt_c), 0);
    reset_c = 1'b0;
    $display("mid-EXEC reset aborted instruction");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
